// File: rtl/xpar_bridge.sv
`default_nettype none
// ============================================================================
// Module  : xpar_bridge
// Brief   : CPU-to-parallel bridge fanning one access at a time out to N_CH
//           external channels; optional access timeout under XPAR_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module xpar_bridge #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int N_CH     = 4,
    parameter int TIMEOUT  = 255,
    localparam int c_ch_w  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int c_off_w = ADDR_W - c_ch_w
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   ready,
    output logic                   err,
    input  logic                   err_clr,
    output logic [c_off_w-1:0]     par_addr,
    output logic [DATA_W-1:0]      par_out,
    output logic [N_CH-1:0]        par_re,
    output logic [N_CH-1:0]        par_we,
    input  logic [N_CH*DATA_W-1:0] par_in,
    input  logic [N_CH-1:0]        par_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ch_w-1:0]   w_ch;
    logic [N_CH-1:0]     w_onehot;
    logic                w_ch_valid;
    logic                w_sel_ack;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_expire;
    logic                w_timeout;
    logic                w_err_set;

    assign w_ch = addr[ADDR_W-1 -: c_ch_w];

    generate
        if (N_CH == (1 << c_ch_w)) begin : g_full_decode
            assign w_ch_valid = 1'b1;
        end else begin : g_part_decode
            localparam logic [c_ch_w:0] c_nch = N_CH[c_ch_w:0];
            assign w_ch_valid = ({1'b0, w_ch} < c_nch);
        end
    endgenerate

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_onehot[i] = (w_ch == c_ch_w'(i));
        end
    end

    // The live strobe doubles as the latched channel select, so only the
    // addressed channel's ack and read data can reach the core.
    assign w_sel_ack = |(par_ack & (par_re | par_we));

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (par_re[i]) begin
                w_sel_data = par_in[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef XPAR_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_expire = (r_state == ACCESS) && (r_cnt == c_cnt_w'(TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    // An ack in the expiry cycle still completes the access cleanly.
    assign w_timeout = w_expire & ~w_sel_ack;
    assign w_err_set = ((r_state == IDLE) & sel & ~w_ch_valid)
                     | ((r_state == ACCESS) & w_timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (sel) begin
                    w_state_nxt = w_ch_valid ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (w_sel_ack || w_expire) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ready = (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            err      <= 1'b0;
            par_addr <= '0;
            par_out  <= '0;
            par_re   <= '0;
            par_we   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sel) begin
                        par_addr <= addr[c_off_w-1:0];
                        par_out  <= data_in;
                        if (w_ch_valid) begin
                            par_re <= we ? '0 : w_onehot;
                            par_we <= we ? w_onehot : '0;
                        end else if (!we) begin
                            // Reads of a missing channel return zero; writes keep data_out.
                            data_out <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (w_sel_ack || w_expire) begin
                        par_re <= '0;
                        par_we <= '0;
                        if (|par_re) begin
                            data_out <= w_sel_ack ? w_sel_data : '0;
                        end
                    end
                end
                default: ;
            endcase
            err <= w_err_set | (err & ~err_clr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xpar_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_xpar_bridge
// Brief   : Transaction-level model and per-cycle compare for xpar_bridge,
//           plus directed checks on a 3-channel instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xpar_bridge;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NCH = 4;
    localparam int TO  = 8;
`ifdef XPAR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main 4-channel instance
    logic              sel = 1'b0, we = 1'b0, err_clr = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     data_in = '0;
    logic [DW-1:0]     data_out;
    logic              ready, err;
    logic [9:0]        par_addr;
    logic [DW-1:0]     par_out;
    logic [NCH-1:0]    par_re, par_we;
    logic [NCH-1:0]    par_ack = '0;
    logic [NCH*DW-1:0] par_in = '0;

    xpar_bridge #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NCH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ready(ready), .err(err), .err_clr(err_clr),
        .par_addr(par_addr), .par_out(par_out), .par_re(par_re), .par_we(par_we),
        .par_in(par_in), .par_ack(par_ack)
    );

    // 3-channel instance: channel index 3 does not exist
    logic            sel3 = 1'b0, we3 = 1'b0, err_clr3 = 1'b0;
    logic [AW-1:0]   addr3 = '0;
    logic [DW-1:0]   data_in3 = '0;
    logic [DW-1:0]   data_out3;
    logic            ready3, err3;
    logic [9:0]      par_addr3;
    logic [DW-1:0]   par_out3;
    logic [2:0]      par_re3, par_we3;
    logic [2:0]      par_ack3 = '0;
    logic [3*DW-1:0] par_in3 = '0;

    xpar_bridge #(.DATA_W(DW), .ADDR_W(AW), .N_CH(3)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .we(we3), .addr(addr3), .data_in(data_in3),
        .data_out(data_out3), .ready(ready3), .err(err3), .err_clr(err_clr3),
        .par_addr(par_addr3), .par_out(par_out3), .par_re(par_re3), .par_we(par_we3),
        .par_in(par_in3), .par_ack(par_ack3)
    );

    int total = 0;
    int bad   = 0;

    // model state, updated at each active edge
    logic           m_err = 1'b0;
    logic [DW-1:0]  m_dout = '0;
    logic [9:0]     m_paddr = '0;
    logic [DW-1:0]  m_pout = '0;
    logic [NCH-1:0] exp_re = '0, exp_we = '0;
    logic           exp_ready = 1'b0;
    bit             chk_en = 1'b0;
    bit             clr_rand = 1'b1;

    // per-transaction observations used by the literal checks
    int             re_cyc = 0, we_cyc = 0, rdy_cyc = 0;
    logic [NCH-1:0] last_re = '0, last_we = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("par_re",   32'(par_re),   32'(exp_re));
            check("par_we",   32'(par_we),   32'(exp_we));
            check("ready",    32'(ready),    32'(exp_ready));
            check("err",      32'(err),      32'(m_err));
            check("data_out", data_out,      m_dout);
            check("par_addr", 32'(par_addr), 32'(m_paddr));
            check("par_out",  par_out,       m_pout);
            if (par_re != '0) begin re_cyc++; last_re = par_re; end
            if (par_we != '0) begin we_cyc++; last_we = par_we; end
            if (ready) rdy_cyc++;
        end
    end

    task automatic clear_stats();
        re_cyc = 0; we_cyc = 0; rdy_cyc = 0; last_re = '0; last_we = '0;
    endtask

    task automatic drive_common();
        err_clr = clr_rand && ($urandom_range(0, 7) == 0);
        par_ack = NCH'($urandom);
        for (int i = 0; i < NCH; i++) par_in[i*DW +: DW] = $urandom;
    endtask

    task automatic step(input bit set_err, input bit upd, input logic [DW-1:0] nd);
        @(posedge clk);
        if (upd) m_dout = nd;
        m_err = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive_common();
            sel = 1'b0;
            exp_re = '0; exp_we = '0; exp_ready = 1'b0;
            step(1'b0, 1'b0, '0);
        end
    endtask

    // One CPU access; the channel acks in ACCESS cycle k (k beyond the
    // timeout means it stays silent until the bridge gives up, if enabled).
    task automatic do_txn(input int ch, input logic [9:0] off, input logic w,
                          input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rd);
        int j;
        bit done, ack, to;
        drive_common();
        exp_re = '0; exp_we = '0; exp_ready = 1'b0;
        sel = 1'b1; we = w; addr = {2'(ch), off}; data_in = wd;
        step(1'b0, 1'b0, '0);
        m_paddr = off;
        m_pout  = wd;
        j = 1;
        done = 1'b0;
        while (!done) begin
            drive_common();
            sel = 1'(($urandom)); we = 1'($urandom); addr = AW'($urandom); data_in = $urandom;
            exp_re = w ? '0 : NCH'(1 << ch);
            exp_we = w ? NCH'(1 << ch) : '0;
            exp_ready = 1'b0;
            ack = (j == k);
            par_ack[ch] = ack;
            if (ack) par_in[ch*DW +: DW] = rd;
            to = TO_EN && (j == TO) && !ack;
            step(to, (ack || to) && !w, ack ? rd : '0);
            done = ack || to;
            j++;
        end
        drive_common();
        sel = 1'($urandom);
        exp_re = '0; exp_we = '0; exp_ready = 1'b1;
        step(1'b0, 1'b0, '0);
        sel = 1'b0;
        exp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    32'(ready),    32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_data_out", data_out,      32'h0);
        check("rst_strobes",  32'({par_re, par_we}), 32'h0);
        check("rst_par_addr", 32'(par_addr), 32'h0);
        check("rst_par_out",  par_out,       32'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // 3-channel instance: valid read, then accesses to the missing channel
        sel3 = 1'b1; we3 = 1'b0; addr3 = {2'd2, 10'h020};
        @(posedge clk); #1;
        check("n3_re",       32'(par_re3),   32'h4);
        check("n3_addr",     32'(par_addr3), 32'h020);
        sel3 = 1'b0; par_ack3 = 3'b100; par_in3[2*DW +: DW] = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        check("n3_rd_ready", 32'(ready3),    32'h1);
        check("n3_rd_data",  data_out3,      32'hA5A5_0F0F);
        par_ack3 = '0;
        @(posedge clk); #1;
        sel3 = 1'b1; we3 = 1'b0; addr3 = {2'd3, 10'h001};
        @(posedge clk); #1;
        check("n3_bad_ready",   32'(ready3), 32'h1);
        check("n3_bad_strobes", 32'({par_re3, par_we3}), 32'h0);
        check("n3_bad_err",     32'(err3),   32'h1);
        check("n3_bad_data",    data_out3,   32'h0);
        sel3 = 1'b0;
        @(posedge clk); #1;
        check("n3_idle_ready",  32'(ready3), 32'h0);
        check("n3_err_sticky",  32'(err3),   32'h1);
        sel3 = 1'b1; we3 = 1'b1; err_clr3 = 1'b1;
        @(posedge clk); #1;
        check("n3_clr_vs_set",  32'(err3),   32'h1);
        sel3 = 1'b0;
        @(posedge clk); #1;
        check("n3_err_clr",     32'(err3),   32'h0);
        err_clr3 = 1'b0;

        // directed read of ch2 with immediate ack
        clr_rand = 1'b0;
        clear_stats();
        do_txn(2, 10'h010, 1'b0, 32'h0BAD_0BAD, 1, 32'hDEAD_BEEF);
        check("rd_re_val",   32'(last_re),  32'h4);
        check("rd_re_cyc",   32'(re_cyc),   32'd1);
        check("rd_addr",     32'(par_addr), 32'h010);
        check("rd_ready",    32'(rdy_cyc),  32'd1);
        check("rd_data",     data_out,      32'hDEAD_BEEF);

        // directed write to ch0 with five wait cycles
        clear_stats();
        do_txn(0, 10'h2A5, 1'b1, 32'h1234_5678, 6, 32'h0);
        check("wr_we_val",   32'(last_we),  32'h1);
        check("wr_we_cyc",   32'(we_cyc),   32'd6);
        check("wr_par_out",  par_out,       32'h1234_5678);
        check("wr_ready",    32'(rdy_cyc),  32'd1);
        check("wr_data_keep", data_out,     32'hDEAD_BEEF);

        // read ch1 which never acks in time while other channels chatter
        clear_stats();
        do_txn(1, 10'h033, 1'b0, 32'h0, 20, 32'h7777_1111);
`ifdef XPAR_TIMEOUT_EN
        check("to_re_cyc",   32'(re_cyc),   32'd8);
        check("to_data",     data_out,      32'h0);
        check("to_err",      32'(err),      32'h1);
        drive_common();
        err_clr = 1'b1;
        sel = 1'b0;
        exp_re = '0; exp_we = '0; exp_ready = 1'b0;
        step(1'b0, 1'b0, '0);
        check("to_err_clr",  32'(err),      32'h0);
`else
        check("wait_re_cyc", 32'(re_cyc),   32'd20);
        check("wait_data",   data_out,      32'h7777_1111);
        check("wait_err",    32'(err),      32'h0);
`endif

        // randomized traffic
        clr_rand = 1'b1;
        for (int t = 0; t < 80; t++) begin
            int ch, k;
            ch = $urandom_range(0, NCH - 1);
            k  = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 12) : $urandom_range(1, 4);
            do_txn(ch, 10'($urandom), 1'($urandom), $urandom, k, $urandom);
            idle($urandom_range(0, 2));
        end

        // make data_out non-zero, then reset in the middle of an access
        clr_rand = 1'b0;
        do_txn(3, 10'h111, 1'b0, 32'h0, 2, 32'h5A5A_C3C3);
        drive_common();
        sel = 1'b1; we = 1'b0; addr = {2'd0, 10'h055}; data_in = 32'h0;
        exp_re = '0; exp_we = '0; exp_ready = 1'b0;
        step(1'b0, 1'b0, '0);
        m_paddr = 10'h055; m_pout = 32'h0;
        drive_common();
        par_ack[0] = 1'b0; sel = 1'b0;
        exp_re = 4'b0001;
        step(1'b0, 1'b0, '0);
        chk_en = 1'b0;
        par_ack = '0; err_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_strobes", 32'({par_re, par_we}), 32'h0);
        check("mid_rst_ready",   32'(ready),    32'h0);
        check("mid_rst_err",     32'(err),      32'h0);
        check("mid_rst_data",    data_out,      32'h0);
        check("mid_rst_addr",    32'(par_addr), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        m_err = 1'b0; m_dout = '0; m_paddr = '0; m_pout = '0;
        exp_re = '0; exp_we = '0; exp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        rd = 32'hCAFE_F00D;
        do_txn(0, 10'h003, 1'b0, 32'h0, 2, rd);
        check("post_rst_read", data_out, 32'hCAFE_F00D);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
